// File: rtl/apu_pkg.sv
// APU shared definitions: register map, length and duty tables,
// and the field layouts of the pulse control and sweep registers.
package apu_pkg;

   typedef enum logic [1:0] {
      REG_CTRL  = 2'd0,
      REG_SWEEP = 2'd1,
      REG_LO    = 2'd2,
      REG_HI    = 2'd3
   } reg_addr_e;

   typedef struct packed {
      logic [1:0] duty;
      logic       halt;
      logic       const_vol;
      logic [3:0] v;
   } ctrl_reg_t;

   typedef struct packed {
      logic       en;
      logic [2:0] p;
      logic       neg;
      logic [2:0] shift;
   } sweep_reg_t;

   // Entry 0 is the rightmost element.
   localparam logic [31:0][7:0] LEN_TABLE = {
      8'd30, 8'd32, 8'd28, 8'd16, 8'd26, 8'd72, 8'd24, 8'd192,
      8'd22, 8'd96, 8'd20, 8'd48, 8'd18, 8'd24, 8'd16, 8'd12,
      8'd14, 8'd26, 8'd12, 8'd14, 8'd10, 8'd60, 8'd8,  8'd160,
      8'd6,  8'd80, 8'd4,  8'd40, 8'd2,  8'd20, 8'd254, 8'd10
   };

   // Bit n of an entry is the output at sequencer step n.
   localparam logic [3:0][7:0] DUTY_TABLE = {
      8'b1001_1111, 8'b0111_1000, 8'b0110_0000, 8'b0100_0000
   };

endpackage

// File: rtl/apu_envelope.sv
// APU envelope generator: decaying or constant volume, clocked by quarter frames.
// Ports: clk, rst (sync, high), quarter_tick, start (restart pulse),
//        loop, const_vol, v (volume/period), volume (envelope output).
module apu_envelope #(
   parameter int VOL_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             quarter_tick,
   input  logic             start,
   input  logic             loop,
   input  logic             const_vol,
   input  logic [VOL_W-1:0] v,
   output logic [VOL_W-1:0] volume
);

   logic             start_flag;
   logic [VOL_W-1:0] decay;
   logic [VOL_W-1:0] divider;

   always_ff @(posedge clk) begin
      if (rst) begin
         start_flag <= 1'b0;
         decay      <= '0;
         divider    <= '0;
      end else begin
         if (quarter_tick) begin
            if (start_flag) begin
               start_flag <= 1'b0;
               decay      <= '1;
               divider    <= v;
            end else if (divider == '0) begin
               divider <= v;
               if (decay != '0)
                  decay <= decay - VOL_W'(1);
               else if (loop)
                  decay <= '1;
            end else begin
               divider <= divider - VOL_W'(1);
            end
         end
         // A restart in the same cycle as a tick lands after the tick.
         if (start)
            start_flag <= 1'b1;
      end
   end

   assign volume = const_vol ? v : decay;

endmodule

// File: rtl/pulse_channel.sv
// NES APU pulse channel: period timer, duty sequencer, envelope, sweep, length.
// Ports: clk, rst (sync, high), apu_tick, quarter_tick, half_tick,
//        wr_en/wr_addr/wr_data (register writes), enable, vol, len_active.
module pulse_channel
   import apu_pkg::*;
#(
   parameter int TIMER_W   = 11,
   parameter int VOL_W     = 4,
   parameter bit ONES_COMP = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             apu_tick,
   input  logic             quarter_tick,
   input  logic             half_tick,
   input  logic             wr_en,
   input  logic [1:0]       wr_addr,
   input  logic [7:0]       wr_data,
   input  logic             enable,
   output logic [VOL_W-1:0] vol,
   output logic             len_active
);

   localparam int RW = TIMER_W + 2;

   ctrl_reg_t          ctrl;
   sweep_reg_t         swp;
   logic               sweep_reload;
   logic [2:0]         sweep_div;
   logic [TIMER_W-1:0] period;
   logic [TIMER_W-1:0] timer;
   logic [2:0]         step;
   logic [7:0]         length;
   logic [VOL_W-1:0]   env_vol;

   logic wr_ctrl, wr_sweep, wr_lo, wr_hi;

   assign wr_ctrl  = wr_en && (wr_addr == REG_CTRL);
   assign wr_sweep = wr_en && (wr_addr == REG_SWEEP);
   assign wr_lo    = wr_en && (wr_addr == REG_LO);
   assign wr_hi    = wr_en && (wr_addr == REG_HI);

   // Sweep target, with a spare sign bit so negated underflow clamps to 0.
   logic [TIMER_W-1:0] delta;
   logic [RW-1:0]      raw;
   logic [TIMER_W:0]   target;
   logic               mute;
   logic               sweep_fire;
   logic               duty_bit;

   assign delta = period >> swp.shift;

   always_comb begin
      raw = {2'b00, period} + {2'b00, delta};
      if (swp.neg)
         raw = {2'b00, period} - {2'b00, delta} - RW'(ONES_COMP);
   end

   assign target = raw[RW-1] ? '0 : raw[TIMER_W:0];
   assign mute   = (period < TIMER_W'(8)) || target[TIMER_W];

   assign sweep_fire = half_tick && (sweep_div == 3'd0) && swp.en
                       && (swp.shift != 3'd0) && !mute;

   assign duty_bit = DUTY_TABLE[ctrl.duty][step];

   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl <= '0;
         swp  <= '0;
      end else begin
         if (wr_ctrl)
            ctrl <= ctrl_reg_t'(wr_data);
         if (wr_sweep)
            swp <= sweep_reg_t'(wr_data);
      end
   end

   // CPU period writes take priority over a sweep update.
   always_ff @(posedge clk) begin
      if (rst)
         period <= '0;
      else if (wr_lo)
         period <= {period[TIMER_W-1:8], wr_data};
      else if (wr_hi)
         period <= {wr_data[TIMER_W-9:0], period[7:0]};
      else if (sweep_fire)
         period <= target[TIMER_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sweep_div    <= 3'd0;
         sweep_reload <= 1'b0;
      end else begin
         if (half_tick) begin
            if ((sweep_div == 3'd0) || sweep_reload) begin
               sweep_div    <= swp.p;
               sweep_reload <= 1'b0;
            end else begin
               sweep_div <= sweep_div - 3'd1;
            end
         end
         if (wr_sweep)
            sweep_reload <= 1'b1;
      end
   end

   // Reg-3 restarts the sequence but leaves the timer phase alone.
   always_ff @(posedge clk) begin
      if (rst) begin
         timer <= '0;
         step  <= 3'd0;
      end else begin
         if (apu_tick) begin
            if (timer == '0) begin
               timer <= period;
               step  <= step - 3'd1;
            end else begin
               timer <= timer - TIMER_W'(1);
            end
         end
         if (wr_hi)
            step <= 3'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         length <= 8'd0;
      else if (!enable)
         length <= 8'd0;
      else if (wr_hi)
         length <= LEN_TABLE[wr_data[7:3]];
      else if (half_tick && (length != 8'd0) && !ctrl.halt)
         length <= length - 8'd1;
   end

   apu_envelope #(
      .VOL_W(VOL_W)
   ) u_env (
      .clk         (clk),
      .rst         (rst),
      .quarter_tick(quarter_tick),
      .start       (wr_hi),
      .loop        (ctrl.halt),
      .const_vol   (ctrl.const_vol),
      .v           (VOL_W'(ctrl.v)),
      .volume      (env_vol)
   );

   always_ff @(posedge clk) begin
      if (rst)
         vol <= '0;
      else if (mute || (length == 8'd0) || !duty_bit)
         vol <= '0;
      else
         vol <= env_vol;
   end

   assign len_active = (length != 8'd0);

endmodule

// File: tb/tb_pulse_channel.sv
// Bench for pulse_channel: directed scenarios plus random traffic
// checked against an integer reference model, on both negate variants.
module tb_pulse_channel;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst = 1'b0;
   logic       apu_tick = 1'b0;
   logic       quarter_tick = 1'b0;
   logic       half_tick = 1'b0;
   logic       wr_en = 1'b0;
   logic [1:0] wr_addr = 2'd0;
   logic [7:0] wr_data = 8'd0;
   logic       enable = 1'b1;
   logic [3:0] vol1, vol0;
   logic       len1, len0;

   int  errors = 0;
   int  checks = 0;
   bit  apu_run = 1'b0;

   pulse_channel #(.TIMER_W(11), .VOL_W(4), .ONES_COMP(1'b1)) dut1 (
      .clk(clk), .rst(rst), .apu_tick(apu_tick),
      .quarter_tick(quarter_tick), .half_tick(half_tick),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .enable(enable), .vol(vol1), .len_active(len1)
   );

   pulse_channel #(.TIMER_W(11), .VOL_W(4), .ONES_COMP(1'b0)) dut0 (
      .clk(clk), .rst(rst), .apu_tick(apu_tick),
      .quarter_tick(quarter_tick), .half_tick(half_tick),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .enable(enable), .vol(vol0), .len_active(len0)
   );

   typedef struct {
      int duty, halt, cons, v;
      int sen, p, neg, shift, reload, sdiv;
      int period, timer, step, len;
      int estart, decay, ediv, vol;
   } mst_t;

   mst_t m1, m0;

   int len_tab[32] = '{10, 254, 20, 2, 40, 4, 80, 6,
                       160, 8, 60, 10, 14, 12, 26, 14,
                       12, 16, 24, 18, 48, 20, 96, 22,
                       192, 24, 72, 26, 16, 28, 32, 30};
   int duty_tab[4] = '{'h40, 'h60, 'h78, 'h9F};

   // One CPU cycle of the channel, straight from the register rules.
   function automatic mst_t mstep(mst_t s, int oc);
      mst_t n;
      int d, t, wd, wa, db, ev;
      bit mute;
      n = s;
      if (rst) begin
         n = '{default: 0};
         return n;
      end
      d = s.period >> s.shift;
      t = s.neg != 0 ? s.period - d - oc : s.period + d;
      if (t < 0) t = 0;
      mute = (s.period < 8) || (t > 2047);
      db = (duty_tab[s.duty] >> s.step) & 1;
      ev = s.cons != 0 ? s.v : s.decay;
      n.vol = (mute || s.len == 0 || db == 0) ? 0 : ev;
      if (apu_tick) begin
         if (s.timer == 0) begin
            n.timer = s.period;
            n.step = (s.step + 7) % 8;
         end else begin
            n.timer = s.timer - 1;
         end
      end
      if (quarter_tick) begin
         if (s.estart != 0) begin
            n.estart = 0;
            n.decay = 15;
            n.ediv = s.v;
         end else if (s.ediv == 0) begin
            n.ediv = s.v;
            if (s.decay > 0) n.decay = s.decay - 1;
            else if (s.halt != 0) n.decay = 15;
         end else begin
            n.ediv = s.ediv - 1;
         end
      end
      if (half_tick) begin
         if (s.len != 0 && s.halt == 0) n.len = s.len - 1;
         if (s.sdiv == 0 && s.sen != 0 && s.shift != 0 && !mute)
            n.period = t;
         if (s.sdiv == 0 || s.reload != 0) begin
            n.sdiv = s.p;
            n.reload = 0;
         end else begin
            n.sdiv = s.sdiv - 1;
         end
      end
      if (wr_en) begin
         wd = int'(wr_data);
         wa = int'(wr_addr);
         case (wa)
            0: begin
               n.duty = (wd >> 6) & 3;
               n.halt = (wd >> 5) & 1;
               n.cons = (wd >> 4) & 1;
               n.v = wd & 15;
            end
            1: begin
               n.sen = (wd >> 7) & 1;
               n.p = (wd >> 4) & 7;
               n.neg = (wd >> 3) & 1;
               n.shift = wd & 7;
               n.reload = 1;
            end
            2: n.period = (s.period & 'h700) | wd;
            default: begin
               n.period = ((wd & 7) << 8) | (s.period & 'hFF);
               n.step = 0;
               n.estart = 1;
               if (enable) n.len = len_tab[wd >> 3];
            end
         endcase
      end
      if (!enable) n.len = 0;
      return n;
   endfunction

   task automatic cyc();
      m1 = mstep(m1, 1);
      m0 = mstep(m0, 0);
      @(posedge clk);
      #1;
      apu_tick = apu_run ? ~apu_tick : 1'b0;
      wr_en = 1'b0;
      quarter_tick = 1'b0;
      half_tick = 1'b0;
   endtask

   task automatic wr(input int a, input int d);
      wr_en = 1'b1;
      wr_addr = a[1:0];
      wr_data = d[7:0];
      cyc();
   endtask

   task automatic qt(input bit h);
      quarter_tick = 1'b1;
      half_tick = h;
      cyc();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      wr_en = 1'b1;
      wr_addr = 2'd3;
      wr_data = 8'h08;
      cyc();
      rst = 1'b0;
      checks++;
      if (vol1 !== 4'd0 || vol0 !== 4'd0) begin
         errors++;
         $display("FAIL reset_vol: got %0d/%0d want 0", vol1, vol0);
      end
      cyc();
      checks++;
      if (len1 !== 1'b0 || len0 !== 1'b0) begin
         errors++;
         $display("FAIL reset_len: got %b/%b want 0", len1, len0);
      end
   endtask

   task automatic test_duty();
      int highs, highs0, rises, bad;
      logic [3:0] prev;
      apu_run = 1'b1;
      wr(0, 'h99);
      wr(1, 'h00);
      wr(2, 'h08);
      wr(3, 'h08);
      repeat (40) cyc();
      highs = 0; highs0 = 0; rises = 0; bad = 0;
      prev = vol1;
      for (int i = 0; i < 288; i++) begin
         cyc();
         if (vol1 == 4'd9) highs++;
         else if (vol1 != 4'd0) bad++;
         if (vol0 == 4'd9) highs0++;
         if (prev == 4'd0 && vol1 == 4'd9) rises++;
         prev = vol1;
      end
      checks++;
      if (highs != 144 || highs0 != 144) begin
         errors++;
         $display("FAIL duty_high: got %0d/%0d want 144", highs, highs0);
      end
      checks++;
      if (rises != 2) begin
         errors++;
         $display("FAIL duty_rises: got %0d want 2", rises);
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL duty_level: got %0d odd samples want 0", bad);
      end
      checks++;
      if (len1 !== 1'b1) begin
         errors++;
         $display("FAIL duty_len: got %b want 1", len1);
      end
   endtask

   task automatic test_envelope();
      int exp;
      apu_run = 1'b0;
      wr(0, 'hE0);
      wr(2, 'h40);
      wr(3, 'h08);
      for (int k = 0; k < 17; k++) begin
         qt(1'b0);
         cyc();
         exp = (k == 16) ? 15 : 15 - k;
         checks++;
         if (vol1 !== 4'(exp) || vol0 !== 4'(exp)) begin
            errors++;
            $display("FAIL env_loop[%0d]: got %0d/%0d want %0d",
                     k, vol1, vol0, exp);
         end
      end
      wr(0, 'hC0);
      wr(3, 'h08);
      repeat (20) qt(1'b0);
      cyc();
      checks++;
      if (vol1 !== 4'd0) begin
         errors++;
         $display("FAIL env_noloop: got %0d want 0", vol1);
      end
      qt(1'b0);
      cyc();
      checks++;
      if (vol1 !== 4'd0 || len1 !== 1'b1) begin
         errors++;
         $display("FAIL env_hold: got vol %0d len %b want 0 1", vol1, len1);
      end
   endtask

   task automatic test_length();
      wr(0, 'hD9);
      wr(3, 'h18);
      cyc();
      checks++;
      if (len1 !== 1'b1) begin
         errors++;
         $display("FAIL len_load: got %b want 1", len1);
      end
      qt(1'b1);
      cyc();
      checks++;
      if (len1 !== 1'b1 || vol1 !== 4'd9) begin
         errors++;
         $display("FAIL len_one: got len %b vol %0d want 1 9", len1, vol1);
      end
      qt(1'b1);
      checks++;
      if (len1 !== 1'b0) begin
         errors++;
         $display("FAIL len_expire: got %b want 0", len1);
      end
      cyc();
      checks++;
      if (vol1 !== 4'd0) begin
         errors++;
         $display("FAIL len_silent: got %0d want 0", vol1);
      end
      wr(3, 'h08);
      enable = 1'b0;
      cyc();
      checks++;
      if (len1 !== 1'b0 || len0 !== 1'b0) begin
         errors++;
         $display("FAIL len_disable: got %b/%b want 0", len1, len0);
      end
      wr(3, 'h08);
      checks++;
      if (len1 !== 1'b0) begin
         errors++;
         $display("FAIL len_disabled_load: got %b want 0", len1);
      end
      enable = 1'b1;
      cyc();
   endtask

   task automatic test_sweep();
      int r1a, r1b, r0a, r0b, nz;
      logic [3:0] p1, p0;
      apu_run = 1'b1;
      wr(0, 'h3F);
      wr(1, 'h89);
      wr(2, 'h00);
      wr(3, 'h01);
      qt(1'b1);
      r1a = -1; r1b = -1; r0a = -1; r0b = -1;
      p1 = vol1; p0 = vol0;
      for (int i = 0; i < 6000; i++) begin
         cyc();
         if (p1 == 4'd0 && vol1 == 4'd15) begin
            if (r1a < 0) r1a = i;
            else if (r1b < 0) r1b = i;
         end
         if (p0 == 4'd0 && vol0 == 4'd15) begin
            if (r0a < 0) r0a = i;
            else if (r0b < 0) r0b = i;
         end
         p1 = vol1; p0 = vol0;
      end
      checks++;
      if (r1a < 0 || r1b - r1a != 2048) begin
         errors++;
         $display("FAIL sweep_ones: got interval %0d want 2048",
                  r1b - r1a);
      end
      checks++;
      if (r0a < 0 || r0b - r0a != 2064) begin
         errors++;
         $display("FAIL sweep_twos: got interval %0d want 2064",
                  r0b - r0a);
      end
      wr(0, 'hFF);
      wr(1, 'h81);
      wr(2, 'h00);
      wr(3, 'h06);
      repeat (4) cyc();
      qt(1'b1);
      nz = 0;
      for (int i = 0; i < 200; i++) begin
         cyc();
         if (vol1 != 4'd0 || vol0 != 4'd0) nz++;
      end
      checks++;
      if (nz != 0) begin
         errors++;
         $display("FAIL sweep_add_mute: got %0d loud cycles want 0", nz);
      end
   endtask

   task automatic test_collision();
      int nz, seen;
      wr(0, 'hD9);
      wr(1, 'h00);
      wr(2, 'h40);
      wr_en = 1'b1;
      wr_addr = 2'd3;
      wr_data = 8'h18;
      qt(1'b1);
      qt(1'b1);
      checks++;
      if (len1 !== 1'b1) begin
         errors++;
         $display("FAIL coll_len: got %b want 1", len1);
      end
      qt(1'b1);
      checks++;
      if (len1 !== 1'b0) begin
         errors++;
         $display("FAIL coll_len_end: got %b want 0", len1);
      end
      wr(2, 'h07);
      wr(3, 'h08);
      nz = 0;
      for (int i = 0; i < 60; i++) begin
         cyc();
         if (vol1 != 4'd0 || vol0 != 4'd0) nz++;
      end
      wr(1, 'h89);
      for (int i = 0; i < 60; i++) begin
         cyc();
         if (vol1 != 4'd0 || vol0 != 4'd0) nz++;
      end
      checks++;
      if (nz != 0) begin
         errors++;
         $display("FAIL coll_p7_mute: got %0d loud cycles want 0", nz);
      end
      wr(2, 'h08);
      seen = 0;
      for (int i = 0; i < 60; i++) begin
         cyc();
         if (vol1 == 4'd9) seen++;
      end
      checks++;
      if (seen == 0) begin
         errors++;
         $display("FAIL coll_p8_sound: got %0d loud cycles want >0", seen);
      end
   endtask

   task automatic test_reset_mid();
      int found, nz;
      found = 0;
      for (int i = 0; i < 100 && found == 0; i++) begin
         cyc();
         if (vol1 == 4'd9) found = 1;
      end
      checks++;
      if (found == 0) begin
         errors++;
         $display("FAIL rstmid_sound: got silence want 9");
      end
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      checks++;
      if (vol1 !== 4'd0 || vol0 !== 4'd0 || len1 !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_state: got vol %0d len %b want 0 0",
                  vol1, len1);
      end
      nz = 0;
      for (int i = 0; i < 200; i++) begin
         cyc();
         if (vol1 != 4'd0 || vol0 != 4'd0) nz++;
      end
      checks++;
      if (nz != 0) begin
         errors++;
         $display("FAIL rstmid_quiet: got %0d loud cycles want 0", nz);
      end
   endtask

   task automatic test_random();
      int rerr;
      bit q;
      rerr = 0;
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      apu_run = 1'b1;
      enable = 1'b1;
      for (int i = 0; i < 30000 && rerr < 10; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            wr_en = 1'b1;
            wr_addr = 2'($urandom_range(0, 3));
            wr_data = 8'($urandom);
            if (wr_addr == 2'd3)
               wr_data[2:1] = 2'b00;
         end
         q = ($urandom_range(0, 39) == 0);
         quarter_tick = q;
         half_tick = q && ($urandom_range(0, 1) == 1);
         if ($urandom_range(0, 1999) == 0) enable = ~enable;
         rst = ($urandom_range(0, 4999) == 0);
         cyc();
         rst = 1'b0;
         checks++;
         if (vol1 !== 4'(m1.vol)) begin
            errors++; rerr++;
            $display("FAIL rand_vol1 @%0d: got %0d want %0d",
                     i, vol1, m1.vol);
         end
         checks++;
         if (vol0 !== 4'(m0.vol)) begin
            errors++; rerr++;
            $display("FAIL rand_vol0 @%0d: got %0d want %0d",
                     i, vol0, m0.vol);
         end
         checks++;
         if (len1 !== (m1.len != 0) || len0 !== (m0.len != 0)) begin
            errors++; rerr++;
            $display("FAIL rand_len @%0d: got %b/%b want %0d/%0d",
                     i, len1, len0, m1.len != 0, m0.len != 0);
         end
      end
   endtask

   initial begin
      m1 = '{default: 0};
      m0 = '{default: 0};
      test_reset();
      test_duty();
      test_envelope();
      test_length();
      test_sweep();
      test_collision();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pulse_channel.md
# pulse_channel

Parametrised NES APU pulse (square) channel with a real 11-bit period timer, 8-step duty sequencer, envelope generator, sweep unit and length counter. It supersedes the fixed-table square generator. One instance serves either pulse 1 or pulse 2; the sweep-negate mode selects which. It sits behind the APU register decoder and frame sequencer, and feeds the mixer with a 4-bit volume per channel.

## Interface
- `TIMER_W`, 11: period timer width; sweep overflow limit is 2^TIMER_W−1.
- `VOL_W`, 4: envelope/volume width.
- `ONES_COMP`, 1: 1 = pulse-1 negate (one's complement), 0 = pulse-2 negate (two's complement).
- `clk  in  1`: CPU clock.
- `rst  in  1`: synchronous, active-high reset.
- `apu_tick  in  1`: timer clock enable, every other CPU cycle.
- `quarter_tick  in  1`: frame-sequencer quarter-frame strobe (envelope).
- `half_tick  in  1`: frame-sequencer half-frame strobe (length, sweep); always coincides with `quarter_tick`.
- `wr_en  in  1`: register write strobe.
- `wr_addr  in  2`: 0..3 → $4000/$4004..$4003/$4007.
- `wr_data  in  8`: write data.
- `enable  in  1`: $4015 channel enable bit.
- `vol  out  VOL_W`: registered channel output.
- `len_active  out  1`: length counter ≠ 0, for the $4015 read.

## Operation
- **Reg 0:** duty[7:6], halt/loop[5], const[4], V[3:0].
- **Reg 1:** sweep en[7], P[6:4], negate[3], shift[2:0]; a write sets `sweep_reload`.
- **Reg 2:** period[7:0].
- **Reg 3:**
  - period[10:8];
  - if `enable`, length ← LEN_TABLE[wr_data[7:3]];
  - sequencer step ← 0;
  - `env_start` ← 1;
  - the timer counter is not reloaded.
- **Timer:** on `apu_tick`, if counter = 0, reload with period and step ← step−1 (mod 8); otherwise decrement.
- **Duty sequences** (index = step, bit 7 = step 7):
  - 0 = 8'b0100_0000
  - 1 = 8'b0110_0000
  - 2 = 8'b0111_1000
  - 3 = 8'b1001_1111
- **Envelope**, on `quarter_tick`:
  - If `env_start`: clear it, decay ← 15, divider ← V.
  - Else if divider = 0: divider ← V, and decay decrements if > 0, or else reloads to 15 when loop is set.
  - Else divider decrements.
  - Envelope volume = const ? V : decay.
- **Length**, on `half_tick`: decrement if ≠ 0 and halt = 0. `enable` = 0 forces length to 0 every cycle.
- **Sweep target:**
  - Δ = period >> shift.
  - Target = period + Δ when not negated.
  - When negated: period − Δ − 1 (`ONES_COMP`=1) or period − Δ (`ONES_COMP`=0).
  - Compute at TIMER_W+1 bits; clamp negative results to 0.
- **Mute:** period < 8, or target > 2^TIMER_W−1. Mute is evaluated continuously, even with sweep disabled.
- **Sweep**, on `half_tick`:
  - If divider = 0 and en and shift ≠ 0 and not mute: period ← target.
  - Then, if divider = 0 or `sweep_reload`: divider ← P and clear reload; else divider decrements.
- **Output:** `vol` ← 0 if mute, or length = 0, or the duty bit = 0; otherwise envelope volume.
- **Reset:** all registers, counters, step, divider, decay and flags are 0; `vol` = 0; `len_active` = 0.

## Timing
- `vol` is registered: one cycle after any internal state change.
- Writes take effect on the cycle after `wr_en`.
- Same-cycle collisions:
  - Reg-3 write + `half_tick`: the length load wins over the decrement.
  - Reg-3 write + `quarter_tick`: the tick processes the old `env_start`; the flag is then set for the next tick.
  - Reg-1 write + `half_tick`: the tick uses the old sweep fields and old reload; the new reload is set afterwards.
  - Reg-2/3 period write + sweep update: the CPU write wins.
  - `rst` overrides all other inputs in the same cycle.
  - `enable` low overrides any length load.

## Structure
- **Package `apu_pkg`:** LEN_TABLE (32×8), DUTY_TABLE (4×8), register address constants.
- **Sub-module `apu_envelope`:** envelope generator, reused later by the noise channel.
- **Timer, sweep and length:** inline.

## Test plan
- **Period 8, duty 2, const V=9, length load index 1 (254):** `vol` toggles 9/0 in a 4-high/4-low pattern over an 18-CPU-cycle step period.
- **Envelope, V=0, loop=1:** `vol` steps 15,14,…,0,15 on successive quarter ticks after a reg-3 write; with loop=0 it holds at 0.
- **Length, halt=0, index 0x03 (2):** after 2 half ticks `len_active`=0 and `vol`=0. Writing `enable`=0 mid-note clears `len_active` in one cycle.
- **Sweep, period 0x100, shift 1, negate, P=0:**
  - `ONES_COMP`=1 → 0x07F.
  - `ONES_COMP`=0 → 0x080.
  - Add mode with period 0x600, shift 1 → muted, period unchanged.
- **Collisions:** reg-3 write coincident with `half_tick` loads length with no decrement; period 7 mutes regardless of sweep enable.
- **Reset mid-note:** `vol`=0 the next cycle; no sound until registers are rewritten.
